// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and downstream memory signals of the two-port memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
);
    // port 0: instruction fetch, read-only
    logic                  mem0_read;
    logic [ADDR_WIDTH-1:0] mem0_address;
    logic [DATA_WIDTH-1:0] mem0_rdata;
    logic                  mem0_resp;

    // port 1: data access, read/write
    logic                  mem1_read;
    logic                  mem1_write;
    logic [ADDR_WIDTH-1:0] mem1_address;
    logic [DATA_WIDTH-1:0] mem1_wdata;
    logic [DATA_WIDTH-1:0] mem1_rdata;
    logic                  mem1_resp;

    // shared downstream memory port
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [DATA_WIDTH-1:0] pmem_wdata;
    logic [DATA_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic                  busy;

    // arbiter side
    modport slave (
        input  mem0_read, mem0_address,
        input  mem1_read, mem1_write, mem1_address, mem1_wdata,
        input  pmem_rdata, pmem_resp,
        output mem0_rdata, mem0_resp,
        output mem1_rdata, mem1_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        output busy
    );

    // requesters and downstream memory side
    modport master (
        output mem0_read, mem0_address,
        output mem1_read, mem1_write, mem1_address, mem1_wdata,
        output pmem_rdata, pmem_resp,
        input  mem0_rdata, mem0_resp,
        input  mem1_rdata, mem1_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SERVE0 = 2'd1;
    localparam logic [1:0] SERVE1 = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic                  last_grant;
    logic                  next_last_grant;
    logic                  req0;
    logic                  req1;

    logic                  pmem_read_c;
    logic                  pmem_write_c;
    logic [ADDR_WIDTH-1:0] pmem_address_c;
    logic [DATA_WIDTH-1:0] pmem_wdata_c;
    logic                  mem0_resp_c;
    logic                  mem1_resp_c;

    assign req0 = bus.mem0_read;
    assign req1 = bus.mem1_read | bus.mem1_write;

    // Grant selection in IDLE; on contention the port not served last wins.
    // Leaving SERVE happens only on pmem_resp, which also records the winner.
    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_grant ? SERVE0 : SERVE1;
                end else if (req1) begin
                    next_state = SERVE1;
                end else if (req0) begin
                    next_state = SERVE0;
                end
            end
            SERVE0: begin
                if (bus.pmem_resp) begin
                    next_state      = IDLE;
                    next_last_grant = 1'b0;
                end
            end
            SERVE1: begin
                if (bus.pmem_resp) begin
                    next_state      = IDLE;
                    next_last_grant = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    // Downstream strobes, address/data mux and response routing follow the
    // current grant; strobes track the live request so a dropped request
    // drops the strobe while the grant is still held.
    always_comb begin
        pmem_read_c    = 1'b0;
        pmem_write_c   = 1'b0;
        pmem_address_c = '0;
        pmem_wdata_c   = '0;
        mem0_resp_c    = 1'b0;
        mem1_resp_c    = 1'b0;
        case (state)
            SERVE0: begin
                pmem_read_c    = bus.mem0_read;
                pmem_address_c = bus.mem0_address;
                mem0_resp_c    = bus.pmem_resp;
            end
            SERVE1: begin
                // a simultaneous read and write is treated as a write
                pmem_read_c    = bus.mem1_read & ~bus.mem1_write;
                pmem_write_c   = bus.mem1_write;
                pmem_address_c = bus.mem1_address;
                pmem_wdata_c   = bus.mem1_wdata;
                mem1_resp_c    = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    assign bus.pmem_read    = pmem_read_c;
    assign bus.pmem_write   = pmem_write_c;
    assign bus.pmem_address = pmem_address_c;
    assign bus.pmem_wdata   = pmem_wdata_c;
    assign bus.mem0_resp    = mem0_resp_c;
    assign bus.mem1_resp    = mem1_resp_c;
    assign bus.mem0_rdata   = bus.pmem_rdata;
    assign bus.mem1_rdata   = bus.pmem_rdata;
    assign bus.busy         = (state == SERVE0) || (state == SERVE1);

endmodule
